// File: rtl/decode_pkg.sv
// Shared decode/execute definitions: control-bundle bit layout, bubble encoding
// and the occupancy states of the decode->execute pipe register.
package decode_pkg;

    localparam int CTRL_WIDTH      = 8;

    localparam int CTRL_BRANCH     = 7;
    localparam int CTRL_REG_WRITE  = 6;
    localparam int CTRL_MEM_READ   = 5;
    localparam int CTRL_MEM_TO_REG = 4;
    localparam int CTRL_ALU_OP_HI  = 3;
    localparam int CTRL_ALU_OP_LO  = 2;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_ALU_SRC    = 0;

    localparam int ALU_OP_WIDTH    = CTRL_ALU_OP_HI - CTRL_ALU_OP_LO + 1;

    localparam logic [31:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        PIPE_EMPTY,
        PIPE_ONE,
        PIPE_FULL
    } pipe_state_e;

    function automatic logic [ALU_OP_WIDTH-1:0] ctrl_alu_op(input logic [CTRL_WIDTH-1:0] ctrl);
        return ctrl[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO];
    endfunction

endpackage

// File: rtl/decode_execute_pipe_slot.sv
// One storage slot of the decode->execute pipe: valid bit plus flat payload register.
// clear wipes valid and payload; drop only invalidates, leaving the payload in place.
module pipe_slot #(
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic             drop,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/decode_execute_pipe.sv
// Decode->execute pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Main slot drives out_*; skid slot absorbs the one entry accepted while execute stalls.
module decode_execute_pipe
    import decode_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int CTRL_WIDTH = decode_pkg::CTRL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  in_pc,
    input  logic [WORD_SIZE-1:0]  in_instruction,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_pc,
    output logic [WORD_SIZE-1:0]  out_instruction,
    output logic [CTRL_WIDTH-1:0] out_ctrl
);

    localparam int SLOT_W = 2 * WORD_SIZE + CTRL_WIDTH;

    pipe_state_e state;
    pipe_state_e state_next;

    logic              accept;
    logic              retire;

    logic              main_load;
    logic              main_clear;
    logic              main_drop;
    logic              main_from_skid;
    logic              main_valid;
    logic [SLOT_W-1:0] main_data;
    logic [SLOT_W-1:0] main_data_in;

    logic              skid_load;
    logic              skid_clear;
    logic              skid_valid;
    logic [SLOT_W-1:0] skid_data;

    logic [SLOT_W-1:0] in_payload;

    assign in_payload = {in_pc, in_instruction, in_ctrl};

    // skid_valid is a flop output, so in_ready has no combinational input path
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;

    assign accept = in_valid && in_ready;
    assign retire = main_valid && out_ready;

    assign main_data_in = main_from_skid ? skid_data : in_payload;

    assign {out_pc, out_instruction, out_ctrl} = main_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= PIPE_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_drop      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (flush) begin
            state_next = PIPE_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                PIPE_EMPTY: begin
                    if (accept) begin
                        main_load  = 1'b1;
                        state_next = PIPE_ONE;
                    end
                end
                PIPE_ONE: begin
                    if (accept && retire) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load  = 1'b1;
                        state_next = PIPE_FULL;
                    end else if (retire) begin
                        main_drop  = 1'b1;
                        state_next = PIPE_EMPTY;
                    end
                end
                PIPE_FULL: begin
                    // in_ready is low here, so only the skid entry can move forward
                    if (retire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_next     = PIPE_ONE;
                    end
                end
                default: begin
                    state_next = PIPE_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    pipe_slot #(
        .WIDTH(SLOT_W)
    ) u_main_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (main_load),
        .clear   (main_clear),
        .drop    (main_drop),
        .data_in (main_data_in),
        .valid   (main_valid),
        .data    (main_data)
    );

    pipe_slot #(
        .WIDTH(SLOT_W)
    ) u_skid_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .drop    (1'b0),
        .data_in (in_payload),
        .valid   (skid_valid),
        .data    (skid_data)
    );

endmodule
